z80_bus_ctrl: RTL and testbench
===============================

// Module: z80_bus_ctrl
// PURPOSE
//  Parametrised bus/interrupt controller between a T80s-style Z80 core and the system.
//  Qualifies raw active-low bus strobes, registers per-access pulses, inserts
//  programmable wait states, latches NUM_IRQ interrupt sources and an edge-triggered
//  NMI, and decodes interrupt acknowledge cycles. Sits beside the CPU core in each
//  board top.
// PARAMETERS
//  ADDR_W    16        CPU address width
//  NUM_IRQ   4         interrupt sources; index 0 has the highest priority
//  INT_VEC   16'h0038  IM1 entry address
//  NMI_VEC   16'h0066  NMI entry address
//  SLOW_LO   16'hE000  first address of the slow memory region
//  SLOW_HI   16'hFFFF  last address of the slow memory region
//  MEM_WAIT  0         wait ticks for slow-region memory access (0..15)
//  IO_WAIT   1         wait ticks for any I/O access (0..15)
//  VEC_BASE  8'hE0     IM2 vector base (used only with the macro)
// PORTS
//  clk       in   1       system clock
//  reset_n   in   1       asynchronous, active-low reset
//  clk_en    in   1       CPU clock enable; all state advances only when high
//  cpu_adr   in   ADDR_W  CPU address
//  cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_rfsh_n, cpu_m1_n  in 1 each  raw CPU strobes
//  ext_wait_n in  1       external wait request, ANDed into cpu_wait_n
//  irq_src   in   NUM_IRQ interrupt sources; rising edge sets pending
//  irq_mask  in   NUM_IRQ 1 = source enabled
//  nmi_src   in   1       NMI source; rising edge sets latch
//  mx, ix, rd, wr, m1  out 1 each  qualified strobes (mx = mreq & rfsh_n), combinational
//  rd_stb    out  1       1-clk pulse at start of any qualified read
//  wr_stb    out  1       1-clk pulse at start of any qualified write
//  cpu_wait_n out 1       to CPU WAIT_n
//  cpu_int_n out  1       to CPU INT_n
//  cpu_nmi_n out  1       to CPU NMI_n
//  intack    out  1       1-clk pulse on interrupt acknowledge
//  nmiack    out  1       1-clk pulse on NMI acknowledge
//  irq_pend  out  NUM_IRQ pending latches
//  vec_out   out  8       IM2 vector byte
// BEHAVIOUR
//  - Reset: rd_stb=wr_stb=intack=nmiack=0; cpu_wait_n=cpu_int_n=cpu_nmi_n=1; irq_pend=0;
//    vec_out=8'hFF; FSM=IDLE. Reset mid-access aborts the wait immediately (wait_n=1).
//  - Access start = (mx|ix)&(rd|wr) rising, sampled on clk_en. Refresh never counts.
//  - rd_stb/wr_stb assert on the clk after the clk_en tick that detects the start.
//  - Wait FSM: IDLE -> start: load cnt = IO_WAIT (ix), MEM_WAIT (mx & SLOW_LO<=adr<=SLOW_HI),
//    else 0; cnt>0 -> WAIT, cnt=0 -> HOLD.
//    WAIT: wait_n=0, cnt-- per clk_en; when cnt reaches 0 -> HOLD.
//    HOLD: wait_n=1 until strobes drop -> IDLE.
//    cpu_wait_n = fsm_wait_n & ext_wait_n.
//  - IRQ: source rising edge (registered per clk_en) sets pend[i];
//    cpu_int_n = ~|(irq_pend & irq_mask).
//  - intack: start of M1 read at INT_VEC, or start of IORQ&M1 cycle. Clears the
//    lowest-index pend bit that is set and enabled. A set and a clear on the same bit
//    in the same tick: set wins.
//  - NMI: rising edge of nmi_src sets latch; cpu_nmi_n = ~latch.
//    nmiack = start of M1 read at NMI_VEC; clears latch (set wins).
// CONFIGURATION
//  Z80BUS_IM2_VECTOR_EN defined: during IORQ&M1, vec_out = VEC_BASE | (idx<<1) of the
//  source being acknowledged; otherwise 8'hFF.
//  Undefined: vec_out constant 8'hFF.
// TESTING
//  - MEM read at 16'hF000, MEM_WAIT=3 -> cpu_wait_n low exactly 3 clk_en ticks;
//    rd_stb one pulse.
//  - MEM read at 16'h1000 -> no wait; refresh cycle (rfsh_n=0) -> no rd_stb, mx=0.
//  - IO write, IO_WAIT=1 -> 1 wait tick, wr_stb pulse; ext_wait_n=0 extends the stall.
//  - irq_src[2] and [1] rise, mask=4'hF -> int_n=0; M1 read 16'h0038 -> intack pulse,
//    pend=4'b0100, int_n stays 0.
//  - nmi_src rise -> nmi_n=0; M1 read 16'h0066 -> nmiack pulse, nmi_n=1.
//  - reset_n low during WAIT -> wait_n=1 and pend=0 immediately.
//    With the macro, INTA with pend[1] -> vec_out=8'hE2.

Source files
------------

// File: rtl/z80_bus_ctrl.sv
// Bus and interrupt controller beside a T80s-style Z80 core: strobe qualification, wait states,
// IRQ/NMI latching and acknowledge decode. Define Z80BUS_IM2_VECTOR_EN for the IM2 vector byte.
module z80_bus_ctrl #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       NUM_IRQ  = 4,
  parameter logic [ADDR_W-1:0] INT_VEC  = 16'h0038,
  parameter logic [ADDR_W-1:0] NMI_VEC  = 16'h0066,
  parameter logic [ADDR_W-1:0] SLOW_LO  = 16'hE000,
  parameter logic [ADDR_W-1:0] SLOW_HI  = 16'hFFFF,
  parameter int unsigned       MEM_WAIT = 0,
  parameter int unsigned       IO_WAIT  = 1,
  parameter logic [7:0]        VEC_BASE = 8'hE0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic [ADDR_W-1:0]  cpu_adr,
  input  logic               cpu_mreq_n,
  input  logic               cpu_iorq_n,
  input  logic               cpu_rd_n,
  input  logic               cpu_wr_n,
  input  logic               cpu_rfsh_n,
  input  logic               cpu_m1_n,
  input  logic               ext_wait_n,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               nmi_src,
  output logic               mx,
  output logic               ix,
  output logic               rd,
  output logic               wr,
  output logic               m1,
  output logic               rd_stb,
  output logic               wr_stb,
  output logic               cpu_wait_n,
  output logic               cpu_int_n,
  output logic               cpu_nmi_n,
  output logic               intack,
  output logic               nmiack,
  output logic [NUM_IRQ-1:0] irq_pend,
  output logic [7:0]         vec_out
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d, load_cnt;
  logic               act, act_q, inta, inta_q, acc_start, inta_start;
  logic               m1_rd_mem, int_hit, nmi_hit, slow, fsm_wait_n;
  logic [NUM_IRQ-1:0] irq_q, pend_q, pend_d, enabled, ack_sel;
  logic               nmi_q, nmi_lat_q, nmi_lat_d;
  logic               rd_stb_q, wr_stb_q, intack_q, nmiack_q;

  assign mx = ~cpu_mreq_n & cpu_rfsh_n;
  assign ix = ~cpu_iorq_n;
  assign rd = ~cpu_rd_n;
  assign wr = ~cpu_wr_n;
  assign m1 = ~cpu_m1_n;

  assign act        = (mx | ix) & (rd | wr);
  assign inta       = ix & m1;
  assign acc_start  = clk_en & act & ~act_q;
  assign inta_start = clk_en & inta & ~inta_q;
  assign m1_rd_mem  = acc_start & m1 & rd & mx;
  assign int_hit    = (m1_rd_mem & (cpu_adr == INT_VEC)) | inta_start;
  assign nmi_hit    = m1_rd_mem & (cpu_adr == NMI_VEC);

  // Widened by one bit so an all-ones upper bound is not a constant comparison.
  assign slow = ({1'b0, cpu_adr} >= {1'b0, SLOW_LO}) & ({1'b0, cpu_adr} <= {1'b0, SLOW_HI});
  assign load_cnt = ix ? 4'(IO_WAIT) : ((mx & slow) ? 4'(MEM_WAIT) : 4'd0);

  assign enabled = pend_q & irq_mask;
  assign ack_sel = enabled & (~enabled + NUM_IRQ'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fsm_wait_n = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (acc_start) begin
          cnt_d   = load_cnt;
          state_d = (load_cnt != 4'd0) ? StWait : StHold;
        end
      end
      StWait: begin
        fsm_wait_n = 1'b0;
        if (clk_en) begin
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = StHold;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StHold: begin
        if (clk_en && !act) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A new request edge in the same tick as an acknowledge keeps the latch set.
  always_comb begin
    pend_d    = pend_q;
    nmi_lat_d = nmi_lat_q;
    if (clk_en) begin
      pend_d    = (pend_q & ~(ack_sel & {NUM_IRQ{int_hit}})) | (irq_src & ~irq_q);
      nmi_lat_d = (nmi_lat_q & ~nmi_hit) | (nmi_src & ~nmi_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      act_q     <= 1'b0;
      inta_q    <= 1'b0;
      irq_q     <= '0;
      pend_q    <= '0;
      nmi_q     <= 1'b0;
      nmi_lat_q <= 1'b0;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      intack_q  <= 1'b0;
      nmiack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      nmi_lat_q <= nmi_lat_d;
      rd_stb_q  <= acc_start & rd;
      wr_stb_q  <= acc_start & wr;
      intack_q  <= int_hit;
      nmiack_q  <= nmi_hit;
      if (clk_en) begin
        act_q  <= act;
        inta_q <= inta;
        irq_q  <= irq_src;
        nmi_q  <= nmi_src;
      end
    end
  end

  assign rd_stb     = rd_stb_q;
  assign wr_stb     = wr_stb_q;
  assign intack     = intack_q;
  assign nmiack     = nmiack_q;
  assign irq_pend   = pend_q;
  assign cpu_wait_n = fsm_wait_n & ext_wait_n;
  assign cpu_int_n  = ~|enabled;
  assign cpu_nmi_n  = ~nmi_lat_q;

`ifdef Z80BUS_IM2_VECTOR_EN
  logic [7:0] vec_q, ack_vec;

  always_comb begin
    ack_vec = 8'hFF;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (enabled[i]) ack_vec = VEC_BASE | 8'(i << 1);
    end
  end

  // Vector is captured at the acknowledge edge, since that edge clears the pending bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_q <= 8'hFF;
    end else if (clk_en) begin
      if (inta_start) vec_q <= ack_vec;
      else if (!inta) vec_q <= 8'hFF;
    end
  end

  assign vec_out = vec_q;
`else
  logic [7:0] unused_vec_base;
  assign unused_vec_base = VEC_BASE;
  assign vec_out         = 8'hFF;
`endif

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Directed bench for z80_bus_ctrl: a transaction-level model is checked every cycle,
// with hand-computed counts and latch values pinning each scenario.
module tb_z80_bus_ctrl;
  localparam int MEM_W = 3;
  localparam int IO_W  = 1;

  logic        clk = 1'b0, reset_n = 1'b0, clk_en = 1'b1;
  logic [15:0] cpu_adr = 16'h0000;
  logic        cpu_mreq_n = 1'b1, cpu_iorq_n = 1'b1, cpu_rd_n = 1'b1, cpu_wr_n = 1'b1;
  logic        cpu_rfsh_n = 1'b1, cpu_m1_n = 1'b1, ext_wait_n = 1'b1, nmi_src = 1'b0;
  logic [3:0]  irq_src = 4'h0, irq_mask = 4'hF;
  logic        mx, ix, rd, wr, m1, rd_stb, wr_stb, cpu_wait_n, cpu_int_n, cpu_nmi_n;
  logic        intack, nmiack;
  logic [3:0]  irq_pend;
  logic [7:0]  vec_out;

  z80_bus_ctrl #(.MEM_WAIT(MEM_W), .IO_WAIT(IO_W)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .cpu_adr(cpu_adr),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n),
    .cpu_wr_n(cpu_wr_n), .cpu_rfsh_n(cpu_rfsh_n), .cpu_m1_n(cpu_m1_n),
    .ext_wait_n(ext_wait_n), .irq_src(irq_src), .irq_mask(irq_mask), .nmi_src(nmi_src),
    .mx(mx), .ix(ix), .rd(rd), .wr(wr), .m1(m1), .rd_stb(rd_stb), .wr_stb(wr_stb),
    .cpu_wait_n(cpu_wait_n), .cpu_int_n(cpu_int_n), .cpu_nmi_n(cpu_nmi_n),
    .intack(intack), .nmiack(nmiack), .irq_pend(irq_pend), .vec_out(vec_out)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int n_wait_lo, n_rd, n_wr, n_ia, n_na;
  bit toggle_en = 1'b0;

  // Model: wait_left counts stalled ticks still owed; holding means an access is in progress.
  bit m_act_prev, m_inta_prev, m_nmi_prev, m_nmi_lat, m_holding;
  bit m_irq_prev[4];
  bit m_pend[4];
  int m_wait_left;
  bit e_rd_stb, e_wr_stb, e_intack, e_nmiack;

  task automatic chk_b(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_v(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [3:0] pend_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    m_act_prev = 0; m_inta_prev = 0; m_nmi_prev = 0; m_nmi_lat = 0; m_holding = 0;
    m_wait_left = 0;
    e_rd_stb = 0; e_wr_stb = 0; e_intack = 0; e_nmiack = 0;
    for (int i = 0; i < 4; i++) begin
      m_irq_prev[i] = 0;
      m_pend[i] = 0;
    end
  endtask

  task automatic model_step();
    bit mx_e, ix_e, rd_e, wr_e, m1_e, act, inta, start, istart, m1rd;
    int sel;
    mx_e = !cpu_mreq_n && cpu_rfsh_n;
    ix_e = !cpu_iorq_n;
    rd_e = !cpu_rd_n;
    wr_e = !cpu_wr_n;
    m1_e = !cpu_m1_n;
    act    = (mx_e || ix_e) && (rd_e || wr_e);
    inta   = ix_e && m1_e;
    start  = clk_en && act && !m_act_prev;
    istart = clk_en && inta && !m_inta_prev;
    m1rd   = start && m1_e && rd_e && mx_e;
    e_rd_stb = start && rd_e;
    e_wr_stb = start && wr_e;
    e_intack = (m1rd && cpu_adr == 16'h0038) || istart;
    e_nmiack = m1rd && cpu_adr == 16'h0066;
    if (clk_en) begin
      if (m_wait_left > 0) m_wait_left--;
      else if (m_holding) begin
        if (!act) m_holding = 0;
      end else if (start) begin
        m_wait_left = ix_e ? IO_W : ((mx_e && cpu_adr >= 16'hE000) ? MEM_W : 0);
        m_holding = 1;
      end
      sel = -1;
      for (int i = 0; i < 4; i++) if (sel < 0 && m_pend[i] && irq_mask[i]) sel = i;
      if (e_intack && sel >= 0) m_pend[sel] = 0;
      for (int i = 0; i < 4; i++) begin
        if (irq_src[i] && !m_irq_prev[i]) m_pend[i] = 1;
        m_irq_prev[i] = irq_src[i];
      end
      if (e_nmiack) m_nmi_lat = 0;
      if (nmi_src && !m_nmi_prev) m_nmi_lat = 1;
      m_nmi_prev  = nmi_src;
      m_act_prev  = act;
      m_inta_prev = inta;
    end
  endtask

  task automatic compare();
    chk_b("mx", mx, !cpu_mreq_n && cpu_rfsh_n);
    chk_b("ix", ix, !cpu_iorq_n);
    chk_b("rd", rd, !cpu_rd_n);
    chk_b("wr", wr, !cpu_wr_n);
    chk_b("m1", m1, !cpu_m1_n);
    chk_b("rd_stb", rd_stb, e_rd_stb);
    chk_b("wr_stb", wr_stb, e_wr_stb);
    chk_b("intack", intack, e_intack);
    chk_b("nmiack", nmiack, e_nmiack);
    chk_b("cpu_wait_n", cpu_wait_n, (m_wait_left == 0) && ext_wait_n);
    chk_b("cpu_int_n", cpu_int_n, (pend_vec() & irq_mask) == 4'h0);
    chk_b("cpu_nmi_n", cpu_nmi_n, !m_nmi_lat);
    chk_v("irq_pend", 8'(irq_pend), 8'(pend_vec()));
`ifndef Z80BUS_IM2_VECTOR_EN
    chk_v("vec_out", vec_out, 8'hFF);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare();
    if (!cpu_wait_n) n_wait_lo++;
    if (rd_stb) n_rd++;
    if (wr_stb) n_wr++;
    if (intack) n_ia++;
    if (nmiack) n_na++;
    if (toggle_en) clk_en = ~clk_en;
  endtask

  task automatic clear_counts();
    n_wait_lo = 0; n_rd = 0; n_wr = 0; n_ia = 0; n_na = 0;
  endtask

  task automatic set_bus(input logic [15:0] a, input bit mreq, input bit iorq, input bit r,
                         input bit w, input bit f, input bit rfsh);
    cpu_adr = a; cpu_mreq_n = !mreq; cpu_iorq_n = !iorq; cpu_rd_n = !r; cpu_wr_n = !w;
    cpu_m1_n = !f; cpu_rfsh_n = !rfsh;
  endtask

  task automatic idle_bus();
    set_bus(16'h0000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic access(input logic [15:0] a, input bit mreq, input bit iorq, input bit r,
                        input bit w, input bit f, input int hold);
    set_bus(a, mreq, iorq, r, w, f, 0);
    repeat (hold) tick();
    idle_bus();
    repeat (2) tick();
  endtask

  task automatic inta_cycle();
    access(16'h00FF, 0, 1, 0, 0, 1, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_b("rst_wait_n", cpu_wait_n, 1'b1);
    chk_b("rst_int_n", cpu_int_n, 1'b1);
    chk_b("rst_nmi_n", cpu_nmi_n, 1'b1);
    chk_b("rst_rd_stb", rd_stb, 1'b0);
    chk_b("rst_intack", intack, 1'b0);
    chk_v("rst_pend", 8'(irq_pend), 8'h00);
    chk_v("rst_vec", vec_out, 8'hFF);
    reset_n = 1'b1;
    repeat (2) tick();

    clear_counts();
    access(16'hF000, 1, 0, 1, 0, 0, 6);
    chk_i("slow_wait_ticks", n_wait_lo, 3);
    chk_i("slow_rd_stb", n_rd, 1);

    clear_counts();
    access(16'h1000, 1, 0, 1, 0, 0, 4);
    chk_i("fast_wait_ticks", n_wait_lo, 0);
    chk_i("fast_rd_stb", n_rd, 1);

    clear_counts();
    set_bus(16'h0040, 1, 0, 1, 0, 0, 1);
    tick();
    chk_b("rfsh_mx", mx, 1'b0);
    repeat (2) tick();
    idle_bus();
    repeat (2) tick();
    chk_i("rfsh_rd_stb", n_rd, 0);

    clear_counts();
    set_bus(16'h0010, 0, 1, 0, 1, 0, 0);
    ext_wait_n = 1'b0;
    repeat (4) tick();
    ext_wait_n = 1'b1;
    repeat (3) tick();
    idle_bus();
    repeat (2) tick();
    chk_i("io_ext_wait_ticks", n_wait_lo, 4);
    chk_i("io_wr_stb", n_wr, 1);

    irq_src = 4'b0110;
    tick();
    chk_b("irq_int_n", cpu_int_n, 1'b0);
    irq_src = 4'h0;
    tick();
    clear_counts();
    access(16'h0038, 1, 0, 1, 0, 1, 4);
    chk_i("im1_intack", n_ia, 1);
    chk_v("im1_pend", 8'(irq_pend), 8'h04);
    chk_b("im1_int_n", cpu_int_n, 1'b0);

    irq_src = 4'b0010;
    tick();
    irq_src = 4'h0;
    tick();
    chk_v("inta_pre_pend", 8'(irq_pend), 8'h06);
    clear_counts();
    set_bus(16'h00FF, 0, 1, 0, 0, 1, 0);
    tick();
`ifdef Z80BUS_IM2_VECTOR_EN
    chk_v("im2_vector", vec_out, 8'hE2);
`endif
    repeat (2) tick();
    idle_bus();
    repeat (2) tick();
    chk_i("inta_intack", n_ia, 1);
    chk_v("inta_pend", 8'(irq_pend), 8'h04);
    inta_cycle();
    chk_v("inta2_pend", 8'(irq_pend), 8'h00);
    chk_b("inta2_int_n", cpu_int_n, 1'b1);

    irq_src = 4'b0001;
    tick();
    irq_src = 4'h0;
    tick();
    irq_src = 4'b0001;
    set_bus(16'h00FF, 0, 1, 0, 0, 1, 0);
    tick();
    chk_v("set_wins_pend", 8'(irq_pend), 8'h01);
    irq_src = 4'h0;
    tick();
    idle_bus();
    repeat (2) tick();
    irq_mask = 4'b1110;
    tick();
    chk_b("masked_int_n", cpu_int_n, 1'b1);
    inta_cycle();
    chk_v("masked_inta_pend", 8'(irq_pend), 8'h01);
    irq_mask = 4'hF;
    inta_cycle();
    chk_v("unmasked_inta_pend", 8'(irq_pend), 8'h00);

    nmi_src = 1'b1;
    tick();
    chk_b("nmi_n_set", cpu_nmi_n, 1'b0);
    nmi_src = 1'b0;
    tick();
    clear_counts();
    access(16'h0066, 1, 0, 1, 0, 1, 4);
    chk_i("nmiack_pulses", n_na, 1);
    chk_b("nmi_n_clr", cpu_nmi_n, 1'b1);

    clear_counts();
    clk_en = 1'b1;
    set_bus(16'hF000, 1, 0, 1, 0, 0, 0);
    toggle_en = 1'b1;
    repeat (14) tick();
    toggle_en = 1'b0;
    clk_en = 1'b1;
    idle_bus();
    repeat (3) tick();
    chk_i("clk_en_wait_clocks", n_wait_lo, 6);
    chk_i("clk_en_rd_stb", n_rd, 1);

    irq_src = 4'b1000;
    tick();
    irq_src = 4'h0;
    tick();
    set_bus(16'hF000, 1, 0, 1, 0, 0, 0);
    repeat (2) tick();
    chk_b("pre_reset_wait_n", cpu_wait_n, 1'b0);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_b("reset_wait_n", cpu_wait_n, 1'b1);
    chk_v("reset_pend", 8'(irq_pend), 8'h00);
    chk_b("reset_int_n", cpu_int_n, 1'b1);
    idle_bus();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
